// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch funct3 codes, resolve-unit state encoding, XLEN default.
// Latency: n/a (package only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

endpackage

// File: rtl/branch_outcome.sv
// Decodes taken/not-taken from comparator flags and funct3; picks comparator signedness.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle regardless of validity.
// Ports: funct3/is_jal/is_jalr/equal/less_than in; taken, sign_select, illegal out.
module branch_outcome
  import cpu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       is_jal,
  input  logic       is_jalr,
  input  logic       equal,
  input  logic       less_than,
  output logic       taken,
  output logic       sign_select,
  output logic       illegal
);

  // Only the unsigned variants ask for an unsigned compare; jumps don't care.
  assign sign_select = ~((funct3 == F3_BLTU) | (funct3 == F3_BGEU));

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (is_jal | is_jalr) begin
      taken = 1'b1;
    end else begin
      case (funct3)
        F3_BEQ:           taken = equal;
        F3_BNE:           taken = ~equal;
        F3_BLT, F3_BLTU:  taken = less_than;
        F3_BGE, F3_BGEU:  taken = ~less_than;
        default:          illegal = 1'b1;  // 010/011: reserved, treated as not taken
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: outcome, target, mispredict redirect, flush, predictor update, stats.
// Latency: all pulses and redirect_pc registered, one cycle after accept; flush lasts FLUSH_CYCLES.
// Backpressure: stall or an active flush blocks acceptance; branches seen during flush are squashed.
// Ports: clk/rst; br_valid, stall, funct3, is_jal, is_jalr, pc, imm, rs1_data, pred_taken,
//        pred_target, equal, less_than in; sign_select, redirect_valid/pc, flush, upd_valid/
//        taken/pc, illegal_branch, branch_count, mispredict_count out.
module branch_resolve_unit
  import cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int XLEN         = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_valid,
  input  logic            stall,
  input  logic [2:0]      funct3,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            pred_taken,
  input  logic [XLEN-1:0] pred_target,
  input  logic            equal,
  input  logic            less_than,
  output logic            sign_select,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            upd_valid,
  output logic            upd_taken,
  output logic [XLEN-1:0] upd_pc,
  output logic            illegal_branch,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            accept;
  logic            taken;
  logic            illegal;
  logic            mispredict;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] correct_pc;

  branch_outcome u_outcome (
    .funct3      (funct3),
    .is_jal      (is_jal),
    .is_jalr     (is_jalr),
    .equal       (equal),
    .less_than   (less_than),
    .taken       (taken),
    .sign_select (sign_select),
    .illegal     (illegal)
  );

  assign accept = br_valid & ~stall & (state == S_IDLE);

  // All sums wrap modulo 2^XLEN; JALR clears bit 0 of its target.
  assign br_target  = pc + imm;
  assign jalr_sum   = rs1_data + imm;
  assign target     = is_jalr ? (jalr_sum & ~XLEN'(1)) : br_target;
  assign seq_pc     = pc + XLEN'(4);
  assign correct_pc = taken ? target : seq_pc;
  assign mispredict = (taken != pred_taken) | (taken & pred_taken & (target != pred_target));

  assign flush = (state == S_FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // cnt holds the flush cycles still to run including the current one.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept & mispredict) begin
          state_nxt = S_FLUSH;
          cnt_nxt   = FLUSH_LOAD;
        end
      end
      S_FLUSH: begin
        if (cnt <= 4'd1) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      upd_valid        <= 1'b0;
      upd_taken        <= 1'b0;
      upd_pc           <= '0;
      illegal_branch   <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      redirect_valid <= accept & mispredict;
      upd_valid      <= accept;
      illegal_branch <= accept & illegal;
      if (accept) begin
        redirect_pc <= correct_pc;
        upd_taken   <= taken;
        upd_pc      <= pc;
        if (branch_count != 32'hFFFF_FFFF)
          branch_count <= branch_count + 32'd1;
        if (mispredict && (mispredict_count != 32'hFFFF_FFFF))
          mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_branch_resolve_unit;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_valid = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic        is_jal = 1'b0;
  logic        is_jalr = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] imm = '0;
  logic [31:0] rs1_data = '0;
  logic        pred_taken = 1'b0;
  logic [31:0] pred_target = '0;
  logic        equal = 1'b0;
  logic        less_than = 1'b0;
  logic        sign_select;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        upd_valid;
  logic        upd_taken;
  logic [31:0] upd_pc;
  logic        illegal_branch;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  branch_resolve_unit #(.FLUSH_CYCLES(FC), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .stall(stall), .funct3(funct3),
    .is_jal(is_jal), .is_jalr(is_jalr), .pc(pc), .imm(imm), .rs1_data(rs1_data),
    .pred_taken(pred_taken), .pred_target(pred_target), .equal(equal), .less_than(less_than),
    .sign_select(sign_select), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_pc(upd_pc),
    .illegal_branch(illegal_branch), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining flush cycles, saturating statistics, expected registered outputs.
  int          m_left = 0;
  logic [31:0] m_bcnt = '0, m_mcnt = '0;
  logic        e_rv = 0, e_uv = 0, e_ut = 0, e_ill = 0;
  logic [31:0] e_rpc = '0, e_upc = '0;

  always @(posedge clk) begin : model
    logic acc, tk, ill, mis;
    logic [31:0] tgt, cpc;
    if (rst) begin
      m_left <= 0; m_bcnt <= '0; m_mcnt <= '0;
      e_rv <= 1'b0; e_uv <= 1'b0; e_ut <= 1'b0; e_ill <= 1'b0;
      e_rpc <= '0; e_upc <= '0;
    end else begin
      acc = br_valid && !stall && (m_left == 0);
      tk  = 1'b0;
      ill = 1'b0;
      if (is_jal || is_jalr) tk = 1'b1;
      else begin
        case (funct3)
          3'd0:       tk = equal;
          3'd1:       tk = !equal;
          3'd4, 3'd6: tk = less_than;
          3'd5, 3'd7: tk = !less_than;
          default:    ill = 1'b1;
        endcase
      end
      tgt = is_jalr ? ((rs1_data + imm) & 32'hFFFF_FFFE) : (pc + imm);
      cpc = tk ? tgt : (pc + 32'd4);
      mis = (tk != pred_taken) || (tk && (tgt != pred_target));
      e_rv  <= acc && mis;
      e_uv  <= acc;
      e_ill <= acc && ill;
      if (acc && mis)     m_left <= FC;
      else if (m_left > 0) m_left <= m_left - 1;
      if (acc) begin
        e_ut  <= tk;
        e_upc <= pc;
        e_rpc <= cpc;
        if (m_bcnt != 32'hFFFF_FFFF) m_bcnt <= m_bcnt + 32'd1;
        if (mis && m_mcnt != 32'hFFFF_FFFF) m_mcnt <= m_mcnt + 32'd1;
      end
    end
  end

  // Per-cycle comparison against the model, just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (chk_en) begin
      chk("flush", 32'(flush), 32'(m_left > 0));
      chk("redirect_valid", 32'(redirect_valid), 32'(e_rv));
      chk("upd_valid", 32'(upd_valid), 32'(e_uv));
      chk("illegal_branch", 32'(illegal_branch), 32'(e_ill));
      chk("branch_count", branch_count, m_bcnt);
      chk("mispredict_count", mispredict_count, m_mcnt);
      chk("sign_select", 32'(sign_select), 32'(!(funct3 == 3'd6 || funct3 == 3'd7)));
      if (e_uv) begin
        chk("upd_taken", 32'(upd_taken), 32'(e_ut));
        chk("upd_pc", upd_pc, e_upc);
        chk("redirect_pc", redirect_pc, e_rpc);
      end
    end
  end

  task automatic send(input logic [2:0] f3, input logic jal, input logic jalr,
                      input logic [31:0] p, input logic [31:0] im, input logic [31:0] r1,
                      input logic pt, input logic [31:0] ptg, input logic eq, input logic lt);
    @(negedge clk);
    br_valid = 1'b1; stall = 1'b0; funct3 = f3; is_jal = jal; is_jalr = jalr;
    pc = p; imm = im; rs1_data = r1; pred_taken = pt; pred_target = ptg;
    equal = eq; less_than = lt;
  endtask

  task automatic nxt();
    @(negedge clk);
    br_valid = 1'b0;
    stall    = 1'b0;
  endtask

  initial begin
    logic [31:0] t;
    rst = 1'b1;
    @(posedge clk);
    chk_en = 1'b1;
    nxt();
    nxt();
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_redirect", 32'(redirect_valid), 32'd0);
    chk("rst_bcnt", branch_count, 32'd0);
    rst = 1'b0;

    // BEQ taken, predicted not taken
    send(3'b000, 0, 0, 32'h100, 32'h20, 32'h0, 0, 32'h0, 1, 0);
    nxt();
    chk("beq_rv", 32'(redirect_valid), 32'd1);
    chk("beq_rpc", redirect_pc, 32'h120);
    chk("beq_flush1", 32'(flush), 32'd1);
    chk("beq_mcnt", mispredict_count, 32'd1);
    nxt();
    chk("beq_flush2", 32'(flush), 32'd1);
    chk("beq_rv_pulse", 32'(redirect_valid), 32'd0);
    nxt();
    chk("beq_flush_end", 32'(flush), 32'd0);

    // BLTU not taken, predicted not taken
    send(3'b110, 0, 0, 32'h200, 32'h40, 32'h0, 0, 32'h0, 0, 0);
    #1 chk("bltu_sign", 32'(sign_select), 32'd0);
    nxt();
    chk("bltu_rv", 32'(redirect_valid), 32'd0);
    chk("bltu_uv", 32'(upd_valid), 32'd1);
    chk("bltu_ut", 32'(upd_taken), 32'd0);
    chk("bltu_bcnt", branch_count, 32'd2);
    chk("bltu_mcnt", mispredict_count, 32'd1);

    // JALR, correct prediction then wrong target
    send(3'b000, 0, 1, 32'h300, 32'h4, 32'h1003, 1, 32'h1006, 0, 0);
    nxt();
    chk("jalr_ok_rv", 32'(redirect_valid), 32'd0);
    chk("jalr_ok_rpc", redirect_pc, 32'h1006);
    send(3'b000, 0, 1, 32'h300, 32'h4, 32'h1003, 1, 32'h1000, 0, 0);
    nxt();
    chk("jalr_bad_rv", 32'(redirect_valid), 32'd1);
    chk("jalr_bad_rpc", redirect_pc, 32'h1006);
    // Branch held during both flush cycles is squashed
    br_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    br_valid = 1'b0;
    chk("squash_bcnt", branch_count, 32'd4);
    chk("squash_uv", 32'(upd_valid), 32'd0);

    // BNE taken with wrap-around target
    send(3'b001, 0, 0, 32'hFFFF_FFF0, 32'h20, 32'h0, 0, 32'h0, 0, 0);
    nxt();
    chk("wrap_rv", 32'(redirect_valid), 32'd1);
    chk("wrap_rpc", redirect_pc, 32'h10);
    nxt();
    nxt();

    // Stalled branch is not consumed
    send(3'b000, 0, 0, 32'h400, 32'h8, 32'h0, 0, 32'h0, 1, 0);
    stall = 1'b1;
    nxt();
    chk("stall_uv", 32'(upd_valid), 32'd0);
    chk("stall_bcnt", branch_count, 32'd5);

    // Reserved funct3
    send(3'b011, 0, 0, 32'h500, 32'h8, 32'h0, 0, 32'h0, 1, 1);
    nxt();
    chk("ill_pulse", 32'(illegal_branch), 32'd1);
    chk("ill_ut", 32'(upd_taken), 32'd0);
    chk("ill_rv", 32'(redirect_valid), 32'd0);

    // Reset during the first flush cycle
    send(3'b000, 0, 0, 32'h100, 32'h20, 32'h0, 0, 32'h0, 1, 0);
    nxt();
    rst = 1'b1;
    nxt();
    chk("rstf_flush", 32'(flush), 32'd0);
    chk("rstf_rv", 32'(redirect_valid), 32'd0);
    chk("rstf_bcnt", branch_count, 32'd0);
    chk("rstf_mcnt", mispredict_count, 32'd0);
    rst = 1'b0;
    send(3'b100, 0, 0, 32'h600, 32'h10, 32'h0, 1, 32'h610, 0, 1);
    nxt();
    chk("post_rst_uv", 32'(upd_valid), 32'd1);
    chk("post_rst_bcnt", branch_count, 32'd1);
    chk("post_rst_rv", 32'(redirect_valid), 32'd0);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 99) == 0);
      br_valid    = ($urandom_range(0, 9) < 7);
      stall       = ($urandom_range(0, 9) < 2);
      funct3      = 3'($urandom_range(0, 7));
      is_jal      = ($urandom_range(0, 9) == 0);
      is_jalr     = !is_jal && ($urandom_range(0, 9) == 0);
      pc          = $urandom & 32'hFFFF_FFFC;
      imm         = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed(12'($urandom)));
      rs1_data    = $urandom;
      equal       = 1'($urandom);
      less_than   = 1'($urandom);
      pred_taken  = 1'($urandom);
      t           = is_jalr ? ((rs1_data + imm) & 32'hFFFF_FFFE) : (pc + imm);
      pred_target = ($urandom_range(0, 1) == 0) ? t : $urandom;
    end
    nxt();
    rst = 1'b0;
    repeat (4) nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
